cpu_bus_responder: RTL and testbench

- FPGA-side bus slave for the physical 6502. Generates PHI0 and responds to CPU accesses that hit a small register window; the bus monitor only observes the same bus.
- Serves read data onto D, captures CPU write data, and gives the front-panel logic a host port for preloading the window, such as reset/IRQ vectors.
- Provides run/halt and single-step control of PHI0.

---
 rtl/cpu_bus_responder.sv | 166 ++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: FPGA-side 6502 bus slave. Generates PHI0 (10 phases of
// the 10 MHz clock per bus cycle), serves a small register window on the CPU
// bus, captures CPU writes, and exposes a host port for preloading the window.
// Optional feature: define BUS_RESPONDER_WPROT_EN to add a wprot input that
// blocks CPU writes into the window.
module cpu_bus_responder #(
  parameter logic [15:0] BASE      = 16'hFFF0,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 CLK10MHZ,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step,
  input  logic [15:0]          A,
  input  logic                 RW,
  input  logic [7:0]           d_in,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  output logic                 data_dir,
  output logic                 phi0,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata,
  output logic                 bus_wr_pulse,
  output logic [ADDR_BITS-1:0] bus_wr_addr,
  output logic                 cycle_done,
  output logic                 halted
`ifdef BUS_RESPONDER_WPROT_EN
  ,
  input  logic                 wprot
`endif
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0]  PH_SAMPLE = 4'd4;
  localparam logic [3:0]  PH_HIGH   = 4'd5;
  localparam logic [3:0]  PH_WRITE  = 4'd8;
  localparam logic [3:0]  PH_LAST   = 4'd9;

  logic [3:0]           r_ph;
  logic                 r_halted;
  logic                 r_step;
  logic                 r_phi0;
  logic                 r_cycle_done;
  logic                 r_hit;
  logic                 r_rw;
  logic [ADDR_BITS-1:0] r_off;
  logic [7:0]           r_d_out;
  logic                 r_d_oe;
  logic                 r_data_dir;
  logic                 r_wr_pulse;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [7:0]           r_host_rdata;
  logic [7:0]           r_mem [DEPTH];

  logic [3:0]           w_ph_nxt;
  logic                 w_halt_nxt;
  logic                 w_go;
  logic                 w_hit;
  logic [ADDR_BITS-1:0] w_off;
  logic                 w_wprot;
  logic                 w_cpu_we;

`ifdef BUS_RESPONDER_WPROT_EN
  assign w_wprot = wprot;
`else
  assign w_wprot = 1'b0;
`endif

  assign w_hit    = (A[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
  assign w_off    = A[ADDR_BITS-1:0];
  // CPU write commits on the edge into phase 9, while d_in is still valid
  assign w_cpu_we = !r_halted && (r_ph == PH_WRITE) && r_hit && !r_rw && !w_wprot;

  // Next phase and halt decision; halting is only considered at the end of a cycle
  always_comb begin
    w_ph_nxt   = r_ph;
    w_halt_nxt = r_halted;
    w_go       = 1'b0;
    if (r_halted) begin
      w_go       = run | r_step;
      w_halt_nxt = ~w_go;
      w_ph_nxt   = 4'd0;
    end else if (r_ph == PH_LAST) begin
      w_ph_nxt   = 4'd0;
      w_halt_nxt = ~run & ~r_step;
    end else begin
      w_ph_nxt   = r_ph + 4'd1;
    end
  end

  // Phase sequencer, run/step control and CPU-facing bus outputs
  always_ff @(posedge CLK10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_ph         <= 4'd0;
      r_halted     <= 1'b0;
      r_step       <= 1'b0;
      r_phi0       <= 1'b0;
      r_cycle_done <= 1'b0;
      r_hit        <= 1'b0;
      r_rw         <= 1'b1;
      r_off        <= '0;
      r_d_out      <= 8'h00;
      r_d_oe       <= 1'b0;
      r_data_dir   <= 1'b1;
      r_wr_pulse   <= 1'b0;
      r_wr_addr    <= '0;
    end else begin
      r_ph         <= w_ph_nxt;
      r_halted     <= w_halt_nxt;
      r_phi0       <= (w_ph_nxt >= PH_HIGH);
      r_cycle_done <= !r_halted && (r_ph == PH_LAST);
      r_wr_pulse   <= w_cpu_we;
      if (w_cpu_we) r_wr_addr <= r_off;

      // A step is only remembered while halted with run low; it is consumed on release
      if (w_go) begin
        r_step <= 1'b0;
      end else if (r_halted && step && !run) begin
        r_step <= 1'b1;
      end

      // Read data is held through phase 0 (100 ns after PHI0 falls), then released
      if (r_ph == 4'd0) begin
        r_d_oe     <= 1'b0;
        r_data_dir <= 1'b1;
      end

      // Address/RW sampled at the end of phase 4; read data goes out with PHI0 high
      if (!r_halted && (r_ph == PH_SAMPLE)) begin
        r_hit <= w_hit;
        r_rw  <= RW;
        r_off <= w_off;
        if (w_hit && RW) begin
          r_d_out    <= r_mem[w_off];
          r_d_oe     <= 1'b1;
          r_data_dir <= 1'b0;
        end
      end
    end
  end

  // Window storage: CPU write first, host write last so the host wins a collision
  always_ff @(posedge CLK10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_mem        <= '{default: 8'h00};
      r_host_rdata <= 8'h00;
    end else begin
      r_host_rdata <= r_mem[host_addr];
      if (w_cpu_we) r_mem[r_off] <= d_in;
      if (host_we)  r_mem[host_addr] <= host_wdata;
    end
  end

  assign d_out        = r_d_out;
  assign d_oe         = r_d_oe;
  assign data_dir     = r_data_dir;
  assign phi0         = r_phi0;
  assign host_rdata   = r_host_rdata;
  assign bus_wr_pulse = r_wr_pulse;
  assign bus_wr_addr  = r_wr_addr;
  assign cycle_done   = r_cycle_done;
  assign halted       = r_halted;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: cycle-level reference model plus directed bus
// transactions with hand-computed literal expectations.
module tb_cpu_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic [15:0] A;
  logic        RW;
  logic [7:0]  d_in;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        wprot;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        data_dir;
  logic        phi0;
  logic [7:0]  host_rdata;
  logic        bus_wr_pulse;
  logic [3:0]  bus_wr_addr;
  logic        cycle_done;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_bus_responder dut (
    .CLK10MHZ     (clk),
    .rst_n        (rst_n),
    .run          (run),
    .step         (step),
    .A            (A),
    .RW           (RW),
    .d_in         (d_in),
    .d_out        (d_out),
    .d_oe         (d_oe),
    .data_dir     (data_dir),
    .phi0         (phi0),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .bus_wr_pulse (bus_wr_pulse),
    .bus_wr_addr  (bus_wr_addr),
    .cycle_done   (cycle_done),
    .halted       (halted)
`ifdef BUS_RESPONDER_WPROT_EN
    ,
    .wprot        (wprot)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ph;
  bit          m_halted, m_steplat, m_hit, m_rw;
  logic [3:0]  m_off;
  logic [7:0]  m_mem [16];
  logic [7:0]  e_dout, e_rdata;
  logic [3:0]  e_waddr;
  logic        e_doe, e_pulse, e_done, e_phi0;

  bit          c_rst, c_run, c_step, c_RW, c_hwe, c_wprot;
  logic [15:0] c_A;
  logic [7:0]  c_din, c_hwd;
  logic [3:0]  c_haddr;

  task automatic model_reset();
    m_ph = 0; m_halted = 0; m_steplat = 0; m_hit = 0; m_rw = 1; m_off = 4'h0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    e_dout = 8'h00; e_rdata = 8'h00; e_waddr = 4'h0;
    e_doe = 0; e_pulse = 0; e_done = 0; e_phi0 = 0;
  endtask

  // One 10 MHz clock of the bus timeline: phases 0..9, PHI0 high in 5..9
  task automatic model_step();
    int nph;
    e_rdata = m_mem[c_haddr];
    e_pulse = 0;
    e_done  = 0;
    if (m_ph == 0) e_doe = 0;
    nph = 0;
    if (m_halted) begin
      if (c_run || m_steplat) begin
        m_halted  = 0;
        m_steplat = 0;
      end else if (c_step) begin
        m_steplat = 1;
      end
    end else begin
      if (m_ph == 4) begin
        m_hit = (c_A >= 16'hFFF0);
        m_rw  = c_RW;
        m_off = c_A[3:0];
        if (m_hit && m_rw) begin
          e_dout = m_mem[m_off];
          e_doe  = 1;
        end
      end
      if (m_ph == 8 && m_hit && !m_rw && !c_wprot) begin
        m_mem[m_off] = c_din;
        e_pulse = 1;
        e_waddr = m_off;
      end
      if (m_ph == 9) begin
        e_done = 1;
        if (!c_run && !m_steplat) m_halted = 1;
      end else begin
        nph = m_ph + 1;
      end
    end
    if (c_hwe) m_mem[c_haddr] = c_hwd;
    m_ph   = nph;
    e_phi0 = (m_ph >= 5);
  endtask

  // Compare process: model advances on every edge, DUT checked 1 ns later
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      c_rst = rst_n; c_run = run; c_step = step; c_A = A; c_RW = RW; c_din = d_in;
      c_hwe = host_we; c_haddr = host_addr; c_hwd = host_wdata; c_wprot = wprot;
      #1;
      if (!c_rst) model_reset();
      else        model_step();
      check("d_out",        32'(d_out),        32'(e_dout));
      check("d_oe",         32'(d_oe),         32'(e_doe));
      check("data_dir",     32'(data_dir),     32'(!e_doe));
      check("phi0",         32'(phi0),         32'(e_phi0));
      check("halted",       32'(halted),       32'(m_halted));
      check("host_rdata",   32'(host_rdata),   32'(e_rdata));
      check("bus_wr_pulse", 32'(bus_wr_pulse), 32'(e_pulse));
      check("bus_wr_addr",  32'(bus_wr_addr),  32'(e_waddr));
      check("cycle_done",   32'(cycle_done),   32'(e_done));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ph(input int n);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (m_ph == n && !m_halted) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ph timeout waiting for phase %0d", n);
    end
  endtask

  task automatic reset_lits(input string tag);
    check({tag, "_d_oe"},       32'(d_oe),         32'h0);
    check({tag, "_data_dir"},   32'(data_dir),     32'h1);
    check({tag, "_d_out"},      32'(d_out),        32'h0);
    check({tag, "_phi0"},       32'(phi0),         32'h0);
    check({tag, "_halted"},     32'(halted),       32'h0);
    check({tag, "_host_rdata"}, 32'(host_rdata),   32'h0);
    check({tag, "_wr_pulse"},   32'(bus_wr_pulse), 32'h0);
    check({tag, "_wr_addr"},    32'(bus_wr_addr),  32'h0);
    check({tag, "_cycle_done"}, 32'(cycle_done),   32'h0);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_we = 1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 0;
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    host_addr = a;
    @(negedge clk);
    check(name, 32'(host_rdata), 32'(exp));
  endtask

  // One CPU bus cycle presented from phase 0; address idles after the cycle
  task automatic cpu_cycle(input logic [15:0] a, input bit rw, input logic [7:0] d,
                           input logic [7:0] exp_rd, input bit exp_hit);
    wait_ph(0);
    A = a; RW = rw; d_in = d;
    wait_ph(5);
    if (rw) begin
      check("rd_doe_ph5", 32'(d_oe), 32'(exp_hit));
      if (exp_hit) check("rd_data", 32'(d_out), 32'(exp_rd));
    end
    wait_ph(9);
    if (!rw) begin
      check("wr_pulse_ph9", 32'(bus_wr_pulse), 32'(exp_hit));
      if (exp_hit) check("wr_addr", 32'(bus_wr_addr), 32'(a[3:0]));
    end
    wait_ph(0);
    if (rw) check("rd_doe_ph0", 32'(d_oe), 32'(exp_hit));
    wait_ph(1);
    check("doe_ph1", 32'(d_oe), 32'h0);
    A = 16'h0000; RW = 1;
  endtask

  initial begin
    int hi, dn, act, r1, r2;
    logic prev;
    rst_n = 0; run = 1; step = 0; A = 16'h0000; RW = 1; d_in = 8'h00;
    host_we = 0; host_addr = 4'h0; host_wdata = 8'h00; wprot = 0;
    repeat (3) @(negedge clk);
    reset_lits("reset");
    rst_n = 1;

    // Free-running PHI0: 5 low / 5 high, cycle_done once per 10 clocks
    hi = 0; dn = 0; act = 0; r1 = -1; r2 = -1; prev = phi0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (phi0) hi++;
      if (cycle_done) dn++;
      if (halted) act++;
      if (phi0 && !prev) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = phi0;
    end
    check("phi0_high_clks", 32'(hi), 32'd15);
    check("cycle_done_cnt", 32'(dn), 32'd3);
    check("halted_run",     32'(act), 32'd0);
    check("phi0_period",    32'(r2 - r1), 32'd10);

    // Preload reset vector bytes and read them back over the CPU bus
    host_write(4'hC, 8'h00);
    host_write(4'hD, 8'hE0);
    host_read(4'hD, 8'hE0, "host_rd_D");
    cpu_cycle(16'hFFFC, 1, 8'h00, 8'h00, 1);
    cpu_cycle(16'hFFFD, 1, 8'h00, 8'hE0, 1);

    // CPU write into window, then outside it
    cpu_cycle(16'hFFF3, 0, 8'h5A, 8'h00, 1);
    host_read(4'h3, 8'h5A, "host_rd_wr3");
    cpu_cycle(16'hFFE3, 0, 8'h77, 8'h00, 0);
    host_read(4'h3, 8'h5A, "host_rd_miss3");

    // Host and CPU write offset 7 on the same edge: host value stays
    wait_ph(0);
    A = 16'hFFF7; RW = 0; d_in = 8'h22;
    wait_ph(8);
    host_we = 1; host_addr = 4'h7; host_wdata = 8'h11;
    wait_ph(9);
    host_we = 0;
    check("coll_pulse", 32'(bus_wr_pulse), 32'h1);
    check("coll_addr",  32'(bus_wr_addr),  32'h7);
    A = 16'h0000; RW = 1;
    @(negedge clk);
    check("coll_mem7", 32'(host_rdata), 32'h11);

`ifdef BUS_RESPONDER_WPROT_EN
    wprot = 1;
    cpu_cycle(16'hFFF3, 0, 8'h99, 8'h00, 0);
    host_read(4'h3, 8'h5A, "wprot_mem3");
    host_write(4'h3, 8'h33);
    host_read(4'h3, 8'h33, "wprot_host_wr");
    wprot = 0;
`endif

    // run dropped mid-cycle: the cycle completes, then PHI0 parks low
    wait_ph(2);
    run = 0;
    wait_ph(9);
    check("halt_pre_halted", 32'(halted), 32'h0);
    @(negedge clk);
    check("halt_halted",    32'(halted),     32'h1);
    check("halt_last_done", 32'(cycle_done), 32'h1);
    repeat (6) @(negedge clk);
    check("halt_phi0",    32'(phi0),   32'h0);
    check("halt_stays",   32'(halted), 32'h1);

    // Single step: exactly one bus cycle of activity
    step = 1;
    @(negedge clk);
    step = 0;
    hi = 0; dn = 0; act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (phi0) hi++;
      if (cycle_done) dn++;
      if (!halted) act++;
    end
    check("step_active_clks", 32'(act), 32'd10);
    check("step_done_cnt",    32'(dn),  32'd1);
    check("step_phi0_high",   32'(hi),  32'd5);
    check("step_rehalted",    32'(halted), 32'h1);

    // step with run=1 must not leave a pending step behind
    run = 1; step = 1;
    @(negedge clk);
    step = 0;
    wait_ph(2);
    run = 0;
    wait_ph(9);
    @(negedge clk);
    dn = 0; act = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (cycle_done) dn++;
      if (!halted) act++;
    end
    check("stepign_active", 32'(act), 32'd0);
    check("stepign_done",   32'(dn),  32'd0);
    run = 1;
    @(negedge clk);
    check("resume_halted", 32'(halted), 32'h0);

    // Reset during phase 7 of a read releases the bus at once
    wait_ph(0);
    A = 16'hFFFD; RW = 1;
    wait_ph(7);
    check("rstmid_doe_before", 32'(d_oe), 32'h1);
    rst_n = 0;
    #1;
    reset_lits("rstmid");
    @(negedge clk);
    @(negedge clk);
    A = 16'h0000;
    rst_n = 1;
    host_read(4'hD, 8'h00, "rstmid_mem_cleared");
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
